// File: rtl/ex_stage_pkg.sv
// Shared widths, stall encoding, HI/LO function codes, divider states and
// packed views of the ID->EX and EX->MEM buses.
package ex_stage_pkg;

  localparam int ID_TO_EX_WD  = 159;
  localparam int EX_TO_MEM_WD = 76;
  localparam int STALL_BUS    = 6;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [5:0] OPCODE_SPECIAL = 6'h00;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  // alu_op bit positions (bit 11 is the MSB)
  localparam int ALU_OPS = 12;
  localparam int OP_ADD  = 11;
  localparam int OP_SUB  = 10;
  localparam int OP_SLT  = 9;
  localparam int OP_SLTU = 8;
  localparam int OP_AND  = 7;
  localparam int OP_NOR  = 6;
  localparam int OP_OR   = 5;
  localparam int OP_XOR  = 4;
  localparam int OP_SLL  = 3;
  localparam int OP_SRL  = 2;
  localparam int OP_SRA  = 1;
  localparam int OP_LUI  = 0;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  sel_alu_src1;
    logic [3:0]  sel_alu_src2;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
  } id_to_ex_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_to_mem_t;

  // True when inst is an opcode-0 instruction with the given function code
  function automatic logic is_special(input logic [31:0] inst, input logic [5:0] funct);
    return (inst[31:26] == OPCODE_SPECIAL) && (inst[5:0] == funct);
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Bundle of the execute stage's pipeline, forwarding and data-SRAM signals.
// slave is the execute stage itself, master is whoever drives it.
interface ex_stage_if;
  import ex_stage_pkg::*;

  logic [STALL_BUS-1:0]    stall;
  logic                    stallreq_for_ex;
  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic                    ex_rf_we;
  logic [4:0]              ex_rf_waddr;
  logic [31:0]             ex_ex_result;
  logic                    data_sram_en;
  logic [3:0]              data_sram_wen;
  logic [31:0]             data_sram_addr;
  logic [31:0]             data_sram_wdata;

  modport master (
    output stall, id_to_ex_bus,
    input  stallreq_for_ex, ex_to_mem_bus, ex_rf_we, ex_rf_waddr, ex_ex_result,
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );

  modport slave (
    input  stall, id_to_ex_bus,
    output stallreq_for_ex, ex_to_mem_bus, ex_rf_we, ex_rf_waddr, ex_ex_result,
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );
endinterface

// File: rtl/ex_stage_div_iter.sv
// Iterative restoring divider: one quotient bit per clock for 32 clocks.
// Works on magnitudes and sign-fixes the results on the final step, so
// quotient/remainder are valid (combinationally) while done is high.
// A zero divisor naturally yields quotient all-ones, remainder = dividend.
module div_iter
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_en,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic        busy_reg;
  logic [4:0]  count_reg;
  logic [31:0] rem_reg;
  logic [31:0] quo_reg;
  logic [31:0] divisor_reg;
  logic        neg_q_reg;
  logic        neg_r_reg;

  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        fits;
  logic [31:0] rem_next;
  logic [31:0] quo_next;

  // Operand magnitudes and one restoring step of the current partial remainder
  always_comb begin
    mag_a    = (signed_en && opa[31]) ? (32'd0 - opa) : opa;
    mag_b    = (signed_en && opb[31]) ? (32'd0 - opb) : opb;
    shifted  = {rem_reg, quo_reg[31]};
    diff     = shifted - {1'b0, divisor_reg};
    fits     = shifted >= {1'b0, divisor_reg};
    rem_next = fits ? diff[31:0] : shifted[31:0];
    quo_next = {quo_reg[30:0], fits};
  end

  // Latch operands on start, then shift one bit per cycle until 32 are done
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg    <= 1'b0;
      count_reg   <= 5'd0;
      rem_reg     <= 32'd0;
      quo_reg     <= 32'd0;
      divisor_reg <= 32'd0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
    end else if (start && !busy_reg) begin
      busy_reg    <= 1'b1;
      count_reg   <= 5'd0;
      rem_reg     <= 32'd0;
      quo_reg     <= mag_a;
      divisor_reg <= mag_b;
      neg_q_reg   <= signed_en & (opa[31] ^ opb[31]);
      neg_r_reg   <= signed_en & opa[31];
    end else if (busy_reg) begin
      rem_reg   <= rem_next;
      quo_reg   <= quo_next;
      count_reg <= count_reg + 5'd1;
      if (count_reg == 5'd31) begin
        busy_reg <= 1'b0;
      end
    end
  end

  assign busy      = busy_reg;
  assign done      = busy_reg && (count_reg == 5'd31);
  assign quotient  = neg_q_reg ? (32'd0 - quo_next) : quo_next;
  assign remainder = neg_r_reg ? (32'd0 - rem_next) : rem_next;

  logic unused_bits;
  assign unused_bits = diff[32];

endmodule

// File: rtl/ex_stage.sv
// Execute stage: EX pipeline register, 12-op ALU, HI/LO with single-cycle
// multiply and iterative divide, data-SRAM request and decode forwarding.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  ex_stage_if.slave  bus
);

  id_to_ex_t  ex_reg;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;
  div_state_e  div_state_reg;

  // EX register: reset, bubble when EX stops but MEM runs, load, or hold
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_reg <= '0;
    end else if (bus.stall[2] == STOP && bus.stall[3] == NO_STOP) begin
      ex_reg <= '0;
    end else if (bus.stall[2] == NO_STOP) begin
      ex_reg <= id_to_ex_t'(bus.id_to_ex_bus);
    end
  end

  logic is_mult, is_multu, is_div, is_divu, is_mfhi, is_mflo, is_mthi, is_mtlo;
  logic div_present;

  // HI/LO instruction decode from the instruction held in EX
  always_comb begin
    is_mult     = is_special(ex_reg.inst, FUNCT_MULT);
    is_multu    = is_special(ex_reg.inst, FUNCT_MULTU);
    is_div      = is_special(ex_reg.inst, FUNCT_DIV);
    is_divu     = is_special(ex_reg.inst, FUNCT_DIVU);
    is_mfhi     = is_special(ex_reg.inst, FUNCT_MFHI);
    is_mflo     = is_special(ex_reg.inst, FUNCT_MFLO);
    is_mthi     = is_special(ex_reg.inst, FUNCT_MTHI);
    is_mtlo     = is_special(ex_reg.inst, FUNCT_MTLO);
    div_present = is_div | is_divu;
  end

  logic [31:0] src1;
  logic [31:0] src2;

  // One-hot operand muxes
  always_comb begin
    src1 = ({32{ex_reg.sel_alu_src1[0]}} & ex_reg.rdata1)
         | ({32{ex_reg.sel_alu_src1[1]}} & ex_reg.pc)
         | ({32{ex_reg.sel_alu_src1[2]}} & {27'd0, ex_reg.inst[10:6]});
    src2 = ({32{ex_reg.sel_alu_src2[0]}} & ex_reg.rdata2)
         | ({32{ex_reg.sel_alu_src2[1]}} & {{16{ex_reg.inst[15]}}, ex_reg.inst[15:0]})
         | ({32{ex_reg.sel_alu_src2[2]}} & 32'd8)
         | ({32{ex_reg.sel_alu_src2[3]}} & {16'd0, ex_reg.inst[15:0]});
  end

  logic [31:0] op_res    [ALU_OPS];
  logic [31:0] op_masked [ALU_OPS];
  logic [31:0] alu_result;

  // Every ALU operation computed in parallel
  always_comb begin
    op_res[OP_ADD]  = src1 + src2;
    op_res[OP_SUB]  = src1 - src2;
    op_res[OP_SLT]  = {31'd0, $signed(src1) < $signed(src2)};
    op_res[OP_SLTU] = {31'd0, src1 < src2};
    op_res[OP_AND]  = src1 & src2;
    op_res[OP_NOR]  = ~(src1 | src2);
    op_res[OP_OR]   = src1 | src2;
    op_res[OP_XOR]  = src1 ^ src2;
    op_res[OP_SLL]  = src2 << src1[4:0];
    op_res[OP_SRL]  = src2 >> src1[4:0];
    op_res[OP_SRA]  = $unsigned($signed(src2) >>> src1[4:0]);
    op_res[OP_LUI]  = {src2[15:0], 16'd0};
  end

  genvar gi;
  generate
    for (gi = 0; gi < ALU_OPS; gi++) begin : g_alu_mask
      assign op_masked[gi] = {32{ex_reg.alu_op[gi]}} & op_res[gi];
    end
  endgenerate

  // OR-combine the selected operation; no op selected gives zero
  always_comb begin
    alu_result = 32'd0;
    for (int i = 0; i < ALU_OPS; i++) begin
      alu_result = alu_result | op_masked[i];
    end
  end

  logic [63:0] prod_signed;
  logic [63:0] prod_unsigned;

  // Full 64-bit products; operands widened explicitly to keep the sign intent visible
  always_comb begin
    prod_signed   = {{32{ex_reg.rdata1[31]}}, ex_reg.rdata1} * {{32{ex_reg.rdata2[31]}}, ex_reg.rdata2};
    prod_unsigned = {32'd0, ex_reg.rdata1} * {32'd0, ex_reg.rdata2};
  end

  logic        div_start;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_quo;
  logic [31:0] div_rem;

  assign div_start = (div_state_reg == DIV_IDLE) && div_present;

  div_iter u_div_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .signed_en (is_div),
    .opa       (ex_reg.rdata1),
    .opb       (ex_reg.rdata2),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Divide sequencing: DONE blocks a restart until EX takes a new instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      div_state_reg <= DIV_IDLE;
    end else begin
      case (div_state_reg)
        DIV_IDLE: if (div_present) div_state_reg <= DIV_RUN;
        DIV_RUN:  if (div_done) div_state_reg <= DIV_DONE;
        DIV_DONE: if (bus.stall[2] == NO_STOP) div_state_reg <= DIV_IDLE;
        default:  div_state_reg <= DIV_IDLE;
      endcase
    end
  end

  // HI/LO writes; repeated writes under hold are harmless
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_reg <= 32'd0;
      lo_reg <= 32'd0;
    end else if (div_state_reg == DIV_RUN && div_done) begin
      hi_reg <= div_rem;
      lo_reg <= div_quo;
    end else if (is_mult) begin
      {hi_reg, lo_reg} <= prod_signed;
    end else if (is_multu) begin
      {hi_reg, lo_reg} <= prod_unsigned;
    end else if (is_mthi) begin
      hi_reg <= ex_reg.rdata1;
    end else if (is_mtlo) begin
      lo_reg <= ex_reg.rdata1;
    end
  end

  logic [31:0] ex_result;
  ex_to_mem_t  mem_out;

  // Result selection and outgoing bus packing
  always_comb begin
    ex_result = is_mfhi ? hi_reg : (is_mflo ? lo_reg : alu_result);
    mem_out.pc           = ex_reg.pc;
    mem_out.data_ram_en  = ex_reg.data_ram_en;
    mem_out.data_ram_wen = ex_reg.data_ram_wen;
    mem_out.sel_rf_res   = ex_reg.sel_rf_res;
    mem_out.rf_we        = ex_reg.rf_we;
    mem_out.rf_waddr     = ex_reg.rf_waddr;
    mem_out.ex_result    = ex_result;
  end

  assign bus.ex_to_mem_bus   = mem_out;
  assign bus.stallreq_for_ex = div_start || (div_state_reg == DIV_RUN);
  assign bus.ex_rf_we        = ex_reg.rf_we;
  assign bus.ex_rf_waddr     = ex_reg.rf_waddr;
  assign bus.ex_ex_result    = ex_result;
  assign bus.data_sram_en    = ex_reg.data_ram_en;
  assign bus.data_sram_wen   = ex_reg.data_ram_wen;
  assign bus.data_sram_addr  = ex_result;
  assign bus.data_sram_wdata = ex_reg.rdata2;

  logic unused_bits;
  assign unused_bits = ^{bus.stall[5:4], bus.stall[1:0], ex_reg.inst[25:16], div_busy};

endmodule

// File: tb/tb_ex_stage.sv
// Randomized bench for ex_stage against a behavioural model of the stage.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_stage_if ex_bus ();

  ex_stage u_dut (
    .clk (clk),
    .rst (rst),
    .bus (ex_bus)
  );

  int test_count = 0;
  int fail_count = 0;

  logic [158:0] m_id;
  logic [31:0]  m_hi;
  logic [31:0]  m_lo;

  task automatic check_value(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    test_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [158:0] pack_id(
    input logic [31:0] pc, input logic [31:0] inst, input logic [11:0] op,
    input logic [2:0] s1, input logic [3:0] s2, input logic en, input logic [3:0] wen,
    input logic we, input logic [4:0] waddr, input logic selres,
    input logic [31:0] r1, input logic [31:0] r2);
    return {pc, inst, op, s1, s2, en, wen, we, waddr, selres, r1, r2};
  endfunction

  function automatic logic [158:0] hilo_id(input logic [5:0] funct, input logic [31:0] r1, input logic [31:0] r2);
    logic [31:0] inst;
    inst = {6'h00, 20'h0, funct};
    return pack_id($urandom, inst, 12'h0, 3'b001, 4'b0001, 1'b0, 4'h0,
                   (funct == FUNCT_MFHI || funct == FUNCT_MFLO), 5'($urandom_range(1, 31)), 1'b0, r1, r2);
  endfunction

  function automatic logic [31:0] ref_alu(input logic [158:0] v);
    logic [31:0] pc, inst, r1, r2, a, b;
    logic [11:0] op;
    logic [2:0]  s1;
    logic [3:0]  s2;
    pc = v[158:127]; inst = v[126:95]; op = v[94:83];
    s1 = v[82:80];   s2 = v[79:76];    r1 = v[63:32]; r2 = v[31:0];
    a = s1[0] ? r1 : s1[1] ? pc : s1[2] ? {27'd0, inst[10:6]} : 32'd0;
    b = s2[0] ? r2 : s2[1] ? {{16{inst[15]}}, inst[15:0]} : s2[2] ? 32'd8
      : s2[3] ? {16'd0, inst[15:0]} : 32'd0;
    case (op)
      12'b1000_0000_0000: return a + b;
      12'b0100_0000_0000: return a - b;
      12'b0010_0000_0000: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      12'b0001_0000_0000: return (a < b) ? 32'd1 : 32'd0;
      12'b0000_1000_0000: return a & b;
      12'b0000_0100_0000: return ~(a | b);
      12'b0000_0010_0000: return a | b;
      12'b0000_0001_0000: return a ^ b;
      12'b0000_0000_1000: return b << a[4:0];
      12'b0000_0000_0100: return b >> a[4:0];
      12'b0000_0000_0010: return $unsigned($signed(b) >>> a[4:0]);
      12'b0000_0000_0001: return {b[15:0], 16'h0};
      default:            return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_result(input logic [158:0] v, input logic [31:0] hi, input logic [31:0] lo);
    logic [31:0] inst;
    inst = v[126:95];
    if (inst[31:26] == 6'h00 && inst[5:0] == FUNCT_MFHI) return hi;
    if (inst[31:26] == 6'h00 && inst[5:0] == FUNCT_MFLO) return lo;
    return ref_alu(v);
  endfunction

  // {remainder, quotient} from plain magnitude arithmetic plus sign rules
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic neg_a, neg_b;
    logic [31:0] ma, mb, q, r;
    neg_a = sgn && a[31];
    neg_b = sgn && b[31];
    ma = neg_a ? -a : a;
    mb = neg_b ? -b : b;
    if (mb == 0) begin
      q = 32'hFFFF_FFFF;
      r = ma;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    if (neg_a ^ neg_b) q = -q;
    if (neg_a) r = -r;
    return {r, q};
  endfunction

  // HI/LO effect of the instruction sitting in EX at a clock edge
  task automatic apply_hilo(input logic [158:0] v);
    logic [31:0] inst, r1, r2;
    longint sa, sb;
    logic [63:0] p;
    inst = v[126:95]; r1 = v[63:32]; r2 = v[31:0];
    if (inst[31:26] == 6'h00) begin
      case (inst[5:0])
        FUNCT_MULT: begin
          sa = longint'($signed(r1));
          sb = longint'($signed(r2));
          p = 64'(sa * sb);
          m_hi = p[63:32]; m_lo = p[31:0];
        end
        FUNCT_MULTU: begin
          p = 64'(r1) * 64'(r2);
          m_hi = p[63:32]; m_lo = p[31:0];
        end
        FUNCT_MTHI: m_hi = r1;
        FUNCT_MTLO: m_lo = r1;
        default: ;
      endcase
    end
  endtask

  // Drive inputs, clock once, advance the model, then settle past the edge
  task automatic cycle(input logic [5:0] stall_v, input logic [158:0] id_v);
    ex_bus.stall = stall_v;
    ex_bus.id_to_ex_bus = id_v;
    @(posedge clk);
    if (rst) begin
      m_id = '0; m_hi = '0; m_lo = '0;
    end else begin
      apply_hilo(m_id);
      if (stall_v[2] && !stall_v[3]) m_id = '0;
      else if (!stall_v[2]) m_id = id_v;
    end
    #1;
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] res;
    logic [75:0] mem;
    res = ref_result(m_id, m_hi, m_lo);
    mem = {m_id[158:127], m_id[75], m_id[74:71], m_id[64], m_id[70], m_id[69:65], res};
    check_value({tag, " ex_to_mem_bus"}, ex_bus.ex_to_mem_bus, mem);
    check_value({tag, " ex_ex_result"}, ex_bus.ex_ex_result, res);
    check_value({tag, " ex_rf_we"}, ex_bus.ex_rf_we, m_id[70]);
    check_value({tag, " ex_rf_waddr"}, ex_bus.ex_rf_waddr, m_id[69:65]);
    check_value({tag, " sram_en"}, ex_bus.data_sram_en, m_id[75]);
    check_value({tag, " sram_wen"}, ex_bus.data_sram_wen, m_id[74:71]);
    check_value({tag, " sram_addr"}, ex_bus.data_sram_addr, res);
    check_value({tag, " sram_wdata"}, ex_bus.data_sram_wdata, m_id[31:0]);
    $display("[TB] %s pc=%h result=%h rf_we=%b waddr=%0d", tag, m_id[158:127], res, m_id[70], m_id[69:65]);
  endtask

  task automatic run_div(input string tag, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] lo_seen, output logic [31:0] hi_seen);
    logic [158:0] id;
    logic [63:0] rq;
    int cnt;
    id = hilo_id(sgn ? FUNCT_DIV : FUNCT_DIVU, a, b);
    cycle(6'b000000, id);
    cnt = 0;
    while (ex_bus.stallreq_for_ex === 1'b1 && cnt < 100) begin
      cnt++;
      cycle(6'b001111, id);
    end
    check_value({tag, " stallreq cycles"}, 128'(cnt), 128'd33);
    rq = ref_div(sgn, a, b);
    m_hi = rq[63:32];
    m_lo = rq[31:0];
    cycle(6'b000000, hilo_id(FUNCT_MFLO, 32'd0, 32'd0));
    check_outputs({tag, " mflo"});
    lo_seen = ex_bus.ex_ex_result;
    cycle(6'b000000, hilo_id(FUNCT_MFHI, 32'd0, 32'd0));
    check_outputs({tag, " mfhi"});
    hi_seen = ex_bus.ex_ex_result;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [158:0] id;
    logic [31:0]  lo_seen, hi_seen, inst;
    logic [11:0]  op;
    logic [5:0]   stall_v;
    int k;

    m_id = '0; m_hi = '0; m_lo = '0;
    rst = 1'b1;
    ex_bus.stall = 6'b0;
    ex_bus.id_to_ex_bus = '0;
    cycle(6'b0, '0);
    cycle(6'b0, '0);
    check_outputs("reset");
    check_value("reset stallreq", ex_bus.stallreq_for_ex, 1'b0);
    check_value("reset ex_to_mem_bus zero", ex_bus.ex_to_mem_bus, 76'd0);
    rst = 1'b0;

    // addiu: 5 + sext(0xFFFF)
    id = pack_id(32'hBFC0_0000, {6'h09, 5'd1, 5'd8, 16'hFFFF}, 12'h800, 3'b001, 4'b0010,
                 1'b0, 4'h0, 1'b1, 5'd8, 1'b0, 32'd5, 32'd0);
    cycle(6'b0, id);
    check_outputs("addiu");
    check_value("addiu result", ex_bus.ex_ex_result, 32'd4);
    check_value("addiu waddr", ex_bus.ex_rf_waddr, 5'd8);
    check_value("addiu we", ex_bus.ex_rf_we, 1'b1);

    // jal link address
    id = pack_id(32'hBFC0_0010, {6'h03, 26'h0}, 12'h800, 3'b010, 4'b0100,
                 1'b0, 4'h0, 1'b1, 5'd31, 1'b0, 32'd0, 32'd0);
    cycle(6'b0, id);
    check_outputs("jal");
    check_value("jal result", ex_bus.ex_ex_result, 32'hBFC0_0018);

    // hold keeps the jal, bubble clears it
    cycle(6'b001111, pack_id(32'h1234, 32'h2000_0001, 12'h020, 3'b001, 4'b0001, 1'b1, 4'hF, 1'b1, 5'd3, 1'b1, 32'h55, 32'hAA));
    check_outputs("hold");
    check_value("hold result", ex_bus.ex_ex_result, 32'hBFC0_0018);
    cycle(6'b000111, pack_id(32'h1234, 32'h2000_0001, 12'h020, 3'b001, 4'b0001, 1'b1, 4'hF, 1'b1, 5'd3, 1'b1, 32'h55, 32'hAA));
    check_outputs("bubble");
    check_value("bubble ex_to_mem_bus", ex_bus.ex_to_mem_bus, 76'd0);

    // randomized ALU traffic under random stall patterns
    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 12);
      op = (k == 12) ? 12'd0 : (12'd1 << k);
      inst = {6'($urandom_range(1, 63)), 26'($urandom)};
      id = pack_id($urandom, inst, op, 3'b001 << $urandom_range(0, 2), 4'b0001 << $urandom_range(0, 3),
                   1'($urandom), 4'($urandom), 1'($urandom), 5'($urandom), 1'($urandom), $urandom, $urandom);
      k = $urandom_range(0, 9);
      stall_v = (k < 7) ? 6'b000000 : (k < 9) ? 6'b001111 : 6'b000111;
      cycle(stall_v, id);
      check_outputs($sformatf("alu%0d", n));
    end

    // directed multiplies
    cycle(6'b0, hilo_id(FUNCT_MULT, 32'h8000_0000, 32'd2));
    cycle(6'b0, hilo_id(FUNCT_MFHI, 32'd0, 32'd0));
    check_outputs("mult mfhi");
    check_value("mult hi", ex_bus.ex_ex_result, 32'hFFFF_FFFF);
    cycle(6'b0, hilo_id(FUNCT_MFLO, 32'd0, 32'd0));
    check_outputs("mult mflo");
    check_value("mult lo", ex_bus.ex_ex_result, 32'd0);
    cycle(6'b0, hilo_id(FUNCT_MULTU, 32'h8000_0000, 32'd2));
    cycle(6'b0, hilo_id(FUNCT_MFHI, 32'd0, 32'd0));
    check_outputs("multu mfhi");
    check_value("multu hi", ex_bus.ex_ex_result, 32'd1);

    // random mult/multu/mthi/mtlo followed by reads of both halves
    for (int n = 0; n < 20; n++) begin
      k = $urandom_range(0, 3);
      cycle(6'b0, hilo_id((k == 0) ? FUNCT_MULT : (k == 1) ? FUNCT_MULTU : (k == 2) ? FUNCT_MTHI : FUNCT_MTLO,
                          $urandom, $urandom));
      cycle(6'b0, hilo_id(FUNCT_MFHI, 32'd0, 32'd0));
      check_outputs($sformatf("hilo%0d mfhi", n));
      cycle(6'b0, hilo_id(FUNCT_MFLO, 32'd0, 32'd0));
      check_outputs($sformatf("hilo%0d mflo", n));
    end

    // signed divide -7 / 2
    run_div("sdiv", 1'b1, 32'hFFFF_FFF9, 32'd2, lo_seen, hi_seen);
    check_value("sdiv lo", lo_seen, 32'hFFFF_FFFD);
    check_value("sdiv hi", hi_seen, 32'hFFFF_FFFF);

    // divu by zero interrupted by reset mid-run
    id = hilo_id(FUNCT_DIVU, 32'd9, 32'd0);
    cycle(6'b0, id);
    for (int n = 0; n < 10; n++) cycle(6'b001111, id);
    check_value("divu running stallreq", ex_bus.stallreq_for_ex, 1'b1);
    rst = 1'b1;
    cycle(6'b001111, id);
    check_value("reset mid-div stallreq", ex_bus.stallreq_for_ex, 1'b0);
    rst = 1'b0;
    cycle(6'b0, hilo_id(FUNCT_MFHI, 32'd0, 32'd0));
    check_outputs("post-reset mfhi");
    check_value("post-reset hi", ex_bus.ex_ex_result, 32'd0);
    cycle(6'b0, hilo_id(FUNCT_MFLO, 32'd0, 32'd0));
    check_outputs("post-reset mflo");
    check_value("post-reset lo", ex_bus.ex_ex_result, 32'd0);

    run_div("divu0", 1'b0, 32'd9, 32'd0, lo_seen, hi_seen);
    check_value("divu0 lo", lo_seen, 32'hFFFF_FFFF);
    check_value("divu0 hi", hi_seen, 32'd9);

    // random divides, including signed divide by zero
    run_div("sdiv0", 1'b1, 32'hFFFF_FF00, 32'd0, lo_seen, hi_seen);
    for (int n = 0; n < 6; n++) begin
      run_div($sformatf("rdiv%0d", n), 1'($urandom), $urandom, (n == 5) ? 32'($urandom_range(1, 9)) : $urandom,
              lo_seen, hi_seen);
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
